// File: rtl/systolic_matmul.sv
// Output-stationary systolic matrix multiplier: streams A then B in row-major order,
// runs a rows_p x cols_p MAC grid, then streams C out row-major.
//
// state   | meaning
// IDLE    | waiting for A[0][0]; ready when enabled
// LOAD_A  | shifting in the rest of A
// LOAD_B  | shifting in B; last accept clears grid pipes (and C unless accumulating)
// COMPUTE | skewed operand feed into the MAC grid for depth+rows+cols-2 cycles
// DRAIN   | presenting C row-major on the result stream
module systolic_matmul #(
  parameter int width_p     = 8,
  parameter int rows_p      = 8,
  parameter int cols_p      = 8,
  parameter int depth_p     = 8,
  parameter int acc_width_p = 2*width_p+$clog2(depth_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   accum_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     data_i,
  output logic                   valid_o,
  input  logic                   yumi_i,
  output logic [acc_width_p-1:0] data_o,
  output logic                   busy_o
);

  localparam int na_lp     = rows_p*depth_p;
  localparam int nb_lp     = depth_p*cols_p;
  localparam int nc_lp     = rows_p*cols_p;
  localparam int ld_max_lp = (na_lp > nb_lp) ? na_lp : nb_lp;
  localparam int ld_w_lp   = (ld_max_lp > 1) ? $clog2(ld_max_lp) : 1;
  localparam int out_w_lp  = (nc_lp > 1) ? $clog2(nc_lp) : 1;
  localparam int steps_lp  = depth_p+rows_p+cols_p-2;
  localparam int cyc_w_lp  = $clog2(steps_lp+1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN} state_e;

  state_e state_q, state_d;
  logic [ld_w_lp-1:0]  ld_cnt_q;
  logic [cyc_w_lp-1:0] cyc_q;
  logic [out_w_lp-1:0] out_cnt_q;
  logic                accum_q;

  logic [width_p-1:0]     a_q      [na_lp];
  logic [width_p-1:0]     b_q      [nb_lp];
  logic [width_p-1:0]     a_in     [nc_lp];
  logic [width_p-1:0]     b_in     [nc_lp];
  logic [width_p-1:0]     a_pipe_q [nc_lp];
  logic [width_p-1:0]     b_pipe_q [nc_lp];
  logic [2*width_p-1:0]   prod     [nc_lp];
  logic [acc_width_p-1:0] acc_q    [nc_lp];

  logic accept, yumi_ok, last_a, last_b, last_step, last_out;
  logic load_a, load_b, enter_compute, step;

  assign ready_o = reset_ni & en_i &
                   (state_q == IDLE || state_q == LOAD_A || state_q == LOAD_B);
  assign valid_o = reset_ni & en_i & (state_q == DRAIN);
  assign busy_o  = reset_ni & (state_q != IDLE);
  assign data_o  = valid_o ? acc_q[out_cnt_q] : '0;

  // flush wins over both handshakes in the same cycle
  assign accept  = en_i & valid_i & ready_o & ~flush_i;
  assign yumi_ok = en_i & valid_o & yumi_i & ~flush_i;

  assign last_a    = (ld_cnt_q == ld_w_lp'(na_lp-1));
  assign last_b    = (ld_cnt_q == ld_w_lp'(nb_lp-1));
  assign last_step = (cyc_q == cyc_w_lp'(steps_lp-1));
  assign last_out  = (out_cnt_q == out_w_lp'(nc_lp-1));

  assign load_a        = accept & (state_q == IDLE || state_q == LOAD_A);
  assign load_b        = accept & (state_q == LOAD_B);
  assign enter_compute = load_b & last_b;
  assign step          = en_i & ~flush_i & (state_q == COMPUTE);

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      if (flush_i) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE:    if (accept) state_d = LOAD_A;
          LOAD_A:  if (accept && last_a) state_d = LOAD_B;
          LOAD_B:  if (accept && last_b) state_d = COMPUTE;
          COMPUTE: if (last_step) state_d = DRAIN;
          DRAIN:   if (yumi_ok && last_out) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      ld_cnt_q  <= '0;
      cyc_q     <= '0;
      out_cnt_q <= '0;
      accum_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (en_i) begin
        if (flush_i) begin
          ld_cnt_q  <= '0;
          cyc_q     <= '0;
          out_cnt_q <= '0;
        end else begin
          case (state_q)
            IDLE: begin
              if (accept) begin
                ld_cnt_q <= ld_w_lp'(1);
                accum_q  <= accum_i;
              end
            end
            LOAD_A: begin
              if (accept) ld_cnt_q <= last_a ? '0 : ld_cnt_q + 1'b1;
            end
            LOAD_B: begin
              if (accept) ld_cnt_q <= last_b ? '0 : ld_cnt_q + 1'b1;
              cyc_q <= '0;
            end
            COMPUTE: begin
              cyc_q     <= last_step ? '0 : cyc_q + 1'b1;
              out_cnt_q <= '0;
            end
            DRAIN: begin
              if (yumi_ok) out_cnt_q <= last_out ? '0 : out_cnt_q + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Operand buffers double as the skew feeders: loading shifts the whole flat buffer,
  // computing shifts each A row left and each B column up once its skew has elapsed.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int n = 0; n < na_lp; n++) a_q[n] <= '0;
    end else if (load_a) begin
      for (int n = 0; n < na_lp-1; n++) a_q[n] <= a_q[n+1];
      a_q[na_lp-1] <= data_i;
    end else if (step) begin
      for (int i = 0; i < rows_p; i++) begin
        if (cyc_q >= cyc_w_lp'(i)) begin
          for (int k = 0; k < depth_p-1; k++) a_q[i*depth_p+k] <= a_q[i*depth_p+k+1];
          a_q[i*depth_p+depth_p-1] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int n = 0; n < nb_lp; n++) b_q[n] <= '0;
    end else if (load_b) begin
      for (int n = 0; n < nb_lp-1; n++) b_q[n] <= b_q[n+1];
      b_q[nb_lp-1] <= data_i;
    end else if (step) begin
      for (int j = 0; j < cols_p; j++) begin
        if (cyc_q >= cyc_w_lp'(j)) begin
          for (int k = 0; k < depth_p-1; k++) b_q[k*cols_p+j] <= b_q[(k+1)*cols_p+j];
          b_q[(depth_p-1)*cols_p+j] <= '0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < rows_p; gi++) begin : g_row
    for (genvar gj = 0; gj < cols_p; gj++) begin : g_col
      localparam int pe_lp = gi*cols_p+gj;
      if (gj == 0) begin : g_a_edge
        assign a_in[pe_lp] = (cyc_q >= cyc_w_lp'(gi)) ? a_q[gi*depth_p] : '0;
      end else begin : g_a_pass
        assign a_in[pe_lp] = a_pipe_q[pe_lp-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in[pe_lp] = (cyc_q >= cyc_w_lp'(gj)) ? b_q[gj] : '0;
      end else begin : g_b_pass
        assign b_in[pe_lp] = b_pipe_q[pe_lp-cols_p];
      end
      assign prod[pe_lp] = {{width_p{1'b0}}, a_in[pe_lp]} * {{width_p{1'b0}}, b_in[pe_lp]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int n = 0; n < nc_lp; n++) begin
        a_pipe_q[n] <= '0;
        b_pipe_q[n] <= '0;
        acc_q[n]    <= '0;
      end
    end else if (enter_compute) begin
      for (int n = 0; n < nc_lp; n++) begin
        a_pipe_q[n] <= '0;
        b_pipe_q[n] <= '0;
        if (!accum_q) acc_q[n] <= '0;
      end
    end else if (step) begin
      for (int n = 0; n < nc_lp; n++) begin
        a_pipe_q[n] <= a_in[n];
        b_pipe_q[n] <= b_in[n];
        acc_q[n]    <= acc_q[n] + acc_width_p'(prod[n]);
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul.sv
// Directed bench for systolic_matmul (8x8x8, 8-bit operands, 20-bit results).
module tb_systolic_matmul;
  localparam int W  = 8;
  localparam int AW = 20;  // one spare bit so the doubled all-ones job does not wrap

  logic          clk_i    = 1'b0;
  logic          reset_ni = 1'b1;
  logic          en_i     = 1'b0;
  logic          flush_i  = 1'b0;
  logic          accum_i  = 1'b0;
  logic          valid_i  = 1'b0;
  logic          yumi_i   = 1'b0;
  logic [W-1:0]  data_i   = '0;
  logic          ready_o, valid_o, busy_o;
  logic [AW-1:0] data_o;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int a_m [64];
  int b_m [64];
  int c_exp [64];
  int c_prev [64];

  always #5 clk_i = ~clk_i;

  systolic_matmul #(
    .width_p(W), .rows_p(8), .cols_p(8), .depth_p(8), .acc_width_p(AW)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .en_i(en_i), .flush_i(flush_i),
    .accum_i(accum_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o), .busy_o(busy_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_identity;
    for (int n = 0; n < 64; n++) begin
      a_m[n]   = (n / 8 == n % 8) ? 1 : 0;
      b_m[n]   = n;
      c_exp[n] = n;
    end
  endtask

  task automatic send_job(input logic acc);
    for (int n = 0; n < 64; n++) begin
      valid_i = 1'b1; data_i = W'(a_m[n]); accum_i = acc;
      #1;
      chk("ready A", ready_o, 1);
      tick;
    end
    for (int n = 0; n < 64; n++) begin
      valid_i = 1'b1; data_i = W'(b_m[n]);
      #1;
      chk("ready B", ready_o, 1);
      tick;
    end
    valid_i = 1'b0; accum_i = 1'b0;
    chk("ready in compute", ready_o, 0);
    chk("busy in compute", busy_o, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (valid_o !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    chk(tag, n, 22);
  endtask

  task automatic drain(input bit bp, input string tag);
    int idx = 0;
    int cyc = 0;
    while (idx < 64 && cyc < 1000) begin
      en_i   = !(bp && cyc >= 10 && cyc < 15);
      yumi_i = bp ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (!en_i) begin
        chk("stall valid", valid_o, 0);
        chk("stall data", data_o, 0);
      end else if (valid_o !== 1'b1) begin
        chk({tag, " valid"}, valid_o, 1);
        break;
      end else begin
        chk(tag, data_o, c_exp[idx]);
        if (yumi_i) idx++;
      end
      tick;
      cyc++;
    end
    en_i = 1'b1; yumi_i = 1'b0;
    #1;
    chk("drain count", idx, 64);
    chk("post drain valid", valid_o, 0);
    chk("post drain busy", busy_o, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    #1 reset_ni = 1'b0;
    en_i = 1'b1;
    #1;
    chk("reset ready", ready_o, 0);
    chk("reset valid", valid_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset data", data_o, 0);
    tick; tick;
    reset_ni = 1'b1;
    #1;
    chk("ready after reset", ready_o, 1);

    // identity
    set_identity();
    send_job(1'b0);
    wait_valid("identity latency");
    drain(1'b0, "identity C");

    // all ones: 8*255*255 = 520200
    for (int n = 0; n < 64; n++) begin a_m[n] = 255; b_m[n] = 255; c_exp[n] = 520200; end
    send_job(1'b0);
    wait_valid("width latency");
    drain(1'b0, "width C");

    // same job accumulated on top
    for (int n = 0; n < 64; n++) c_exp[n] = 1040400;
    send_job(1'b1);
    wait_valid("accum latency");
    drain(1'b0, "accum C");

    // identity under backpressure and a 5-cycle enable gap
    set_identity();
    send_job(1'b0);
    wait_valid("bp latency");
    drain(1'b1, "bp C");

    // general pattern against a reference product
    for (int n = 0; n < 64; n++) begin
      a_m[n] = (n * 7 + 3) % 16;
      b_m[n] = (n * 5 + 1) % 13;
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        c_exp[i*8+j] = 0;
        for (int k = 0; k < 8; k++) c_exp[i*8+j] += a_m[i*8+k] * b_m[k*8+j];
      end
    send_job(1'b0);
    wait_valid("mixed latency");
    drain(1'b0, "mixed C");
    for (int n = 0; n < 64; n++) c_prev[n] = c_exp[n];

    // flush mid-load with valid_i still high, then accumulate identity on kept C
    for (int n = 0; n < 10; n++) begin
      valid_i = 1'b1; data_i = 8'd9;
      tick;
    end
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    chk("load flush busy", busy_o, 0);
    chk("load flush ready", ready_o, 1);
    set_identity();
    for (int n = 0; n < 64; n++) c_exp[n] = c_prev[n] + n;
    send_job(1'b1);
    wait_valid("flush accum latency");
    drain(1'b0, "flush accum C");

    // flush at compute cycle 5
    set_identity();
    send_job(1'b0);
    repeat (5) tick;
    flush_i = 1'b1;
    #1;
    chk("compute busy before flush", busy_o, 1);
    tick;
    flush_i = 1'b0;
    #1;
    chk("compute flush busy", busy_o, 0);
    chk("compute flush ready", ready_o, 1);

    // reset in the middle of drain
    send_job(1'b0);
    wait_valid("pre reset latency");
    repeat (3) begin
      yumi_i = 1'b1;
      tick;
    end
    yumi_i = 1'b0;
    #1;
    chk("mid drain valid", valid_o, 1);
    chk("mid drain data", data_o, 3);
    reset_ni = 1'b0;
    #1;
    chk("drain reset valid", valid_o, 0);
    chk("drain reset data", data_o, 0);
    chk("drain reset busy", busy_o, 0);
    chk("drain reset ready", ready_o, 0);
    tick;
    reset_ni = 1'b1;
    send_job(1'b0);
    wait_valid("post reset latency");
    drain(1'b0, "post reset C");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/systolic_matmul.md
SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

Interface
REQ-001 SHALL have parameter width_p, default 8: unsigned operand width in bits.
REQ-002 SHALL have parameter rows_p, default 8: rows of A and C, and rows of the MAC grid.
REQ-003 SHALL have parameter cols_p, default 8: columns of B and C, and columns of the MAC grid.
REQ-004 SHALL have parameter depth_p, default 8: inner dimension K (columns of A, rows of B).
REQ-005 SHALL have parameter acc_width_p, default 2*width_p+$clog2(depth_p): accumulator and result width.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 SHALL have port reset_ni, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port en_i, input, 1 bit: global enable; low freezes all state and counters.
REQ-009 SHALL have port flush_i, input, 1 bit: synchronous abort to IDLE.
REQ-010 SHALL have port accum_i, input, 1 bit: sampled at the first accepted element of a job; 1 adds the new product to the held C, 0 starts C from zero.
REQ-011 SHALL have ports valid_i (input, 1 bit), ready_o (output, 1 bit) and data_i (input, width_p bits): operand stream.
REQ-012 SHALL have ports valid_o (output, 1 bit), yumi_i (input, 1 bit) and data_o (output, acc_width_p bits): result stream.
REQ-013 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement the state machine IDLE -> LOAD_A -> LOAD_B -> COMPUTE -> DRAIN -> IDLE.
REQ-015 SHALL accept an operand only when valid_i & ready_o & en_i are all high.
REQ-016 SHALL assert ready_o only in IDLE, LOAD_A and LOAD_B while en_i is high.
REQ-017 SHALL, on an accepted element in IDLE, store it as A[0][0] and move to LOAD_A.
REQ-018 SHALL load A row-major (rows_p*depth_p elements), then B row-major (depth_p*cols_p elements), into internal operand buffers.
REQ-019 SHALL enter COMPUTE on the cycle after the last B element is accepted; ready_o SHALL be low from that cycle on.
REQ-020 SHALL, in COMPUTE, feed A rows skewed by row index and B columns skewed by column index into the rows_p x cols_p MAC grid, so PE(i,j) accumulates A[i][k]*B[k][j].
REQ-021 SHALL stay in COMPUTE for exactly depth_p+rows_p+cols_p-2 en_i-high cycles, then enter DRAIN.
REQ-022 SHALL do all arithmetic unsigned; each product is zero-extended to acc_width_p; accumulation wraps modulo 2^acc_width_p.
REQ-023 SHALL clear every accumulator on entry to COMPUTE when the captured accum_i is 0, and retain it when accum_i is 1.
REQ-024 SHALL, in DRAIN, present C row-major with valid_o high from the first DRAIN cycle; data_o is stable while valid_o is high and yumi_i is low.
REQ-025 SHALL treat yumi_i as valid only while valid_o is high; each yumi_i & en_i advances to the next element.
REQ-026 SHALL go to IDLE the cycle after the yumi of element rows_p*cols_p-1, with valid_o low in that cycle.
REQ-027 SHALL, while en_i is low, hold all state and hold valid_o, data_o and ready_o low; yumi_i and valid_i are ignored.
REQ-028 SHALL, on flush_i high with en_i high, go to IDLE next cycle, discard partial loads, and keep accumulators for the next accum_i=1 job; flush_i has priority over every handshake in the same cycle.

Reset
REQ-029 SHALL, while reset_ni is low, immediately force state IDLE, all counters to 0, all accumulators to 0, and ready_o, valid_o and busy_o to 0.
REQ-030 SHALL drive data_o to 0 during reset and whenever valid_o is low.
REQ-031 SHALL accept a new job from the first rising edge after reset_ni deasserts, including when reset is asserted mid-load, mid-compute or mid-drain.

Verification
REQ-032 SHALL be checked for identity: A=I (8x8), B[k][j]=8k+j, accum_i=0 -> C[i][j]=8i+j; first valid_o exactly 22 en cycles after the last B accept.
REQ-033 SHALL be checked for width: all operands 255, accum_i=0 -> every C element 520200, with no truncation.
REQ-034 SHALL be checked for accumulate mode: the REQ-033 job repeated with accum_i=1 -> every element 1040400.
REQ-035 SHALL be checked for backpressure: yumi_i toggling 1-of-3 cycles and en_i low for 5 cycles mid-drain -> 64 elements delivered in order, none repeated or lost, with data_o stable while stalled.
REQ-036 SHALL be checked for flush and reset: flush_i at COMPUTE cycle 5 -> IDLE next cycle with ready_o=1; reset_ni low mid-DRAIN -> valid_o=0 immediately, then the next identity job is correct.
